// File: rtl/gate_stream_if.sv
// Signal bundle around gate_stream_scheduler: run control, upstream cell stream,
// serial gate decoder handshake and the matrix offer to the state-vector multiplier.
interface gate_stream_if #(
  parameter int unsigned NUMBER_BITS = 37,
  parameter int unsigned COUNT_BITS  = 8
);
  logic                          start;
  logic [COUNT_BITS-1:0]         gate_count;
  logic                          busy;
  logic                          done;
  logic                          error;
  logic [COUNT_BITS-1:0]         gate_index;

  logic                          src_valid;
  logic signed [NUMBER_BITS-1:0] src_data;
  logic                          src_ready;

  logic                          dec_reset;
  logic signed [NUMBER_BITS-1:0] dec_cell;
  logic                          dec_ready;
  logic                          dec_needs_number;
  logic                          dec_done;

  logic                          apply_valid;
  logic                          apply_ready;

  modport slave (
    input  start, gate_count, src_valid, src_data, dec_needs_number, dec_done, apply_ready,
    output busy, done, error, gate_index, src_ready, dec_reset, dec_cell, dec_ready, apply_valid
  );

  modport master (
    output start, gate_count, src_valid, src_data, dec_needs_number, dec_done, apply_ready,
    input  busy, done, error, gate_index, src_ready, dec_reset, dec_cell, dec_ready, apply_valid
  );
endinterface

// File: rtl/gate_stream_scheduler.sv
// Sequences the serial 2x2 gate decoder over a run of gates. Optional source-stall
// fault detection is compiled in with the GATE_TIMEOUT_EN macro.
module gate_stream_scheduler #(
  parameter int unsigned NUMBER_BITS    = 37,
  parameter int unsigned COUNT_BITS     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic          clk,
  input logic          reset_n,
  gate_stream_if.slave bus
);

`ifdef GATE_TIMEOUT_EN
  typedef enum logic [2:0] {StIdle, StClear, StLoad, StApply, StFault} state_e;
  localparam int unsigned StallBits = $clog2(TIMEOUT_CYCLES + 1);
  logic [StallBits-1:0] stall_q, stall_d;
`else
  typedef enum logic [1:0] {StIdle, StClear, StLoad, StApply} state_e;
`endif

  state_e                state_q, state_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic [COUNT_BITS-1:0] index_q, index_d;
  logic                  credit_q, credit_d;
  logic                  done_q, done_d;

  logic src_ready;
  logic xfer;
  logic apply_hs;
  logic last_gate;

  // Credit remembers a decoder request that arrived while the source had nothing to give.
  assign src_ready = reset_n && (state_q == StLoad) && (credit_q || bus.dec_needs_number);
  assign xfer      = src_ready && bus.src_valid;
  assign apply_hs  = reset_n && (state_q == StApply) && bus.apply_ready;
  assign last_gate = (index_q == count_q - COUNT_BITS'(1));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    index_d  = index_q;
    credit_d = credit_q;
    done_d   = 1'b0;
`ifdef GATE_TIMEOUT_EN
    stall_d  = '0;
`endif
    unique case (state_q)
      StIdle: begin
        credit_d = 1'b0;
        if (bus.start) begin
          if (bus.gate_count != '0) begin
            count_d = bus.gate_count;
            index_d = '0;
            state_d = StClear;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StClear: begin
        credit_d = 1'b0;
        state_d  = StLoad;
      end
      StLoad: begin
        if (xfer) begin
          credit_d = 1'b0;
        end else if (bus.dec_needs_number) begin
          credit_d = 1'b1;
        end
        if (bus.dec_done) begin
          credit_d = 1'b0;
          state_d  = StApply;
        end
`ifdef GATE_TIMEOUT_EN
        else if (src_ready && !bus.src_valid) begin
          stall_d = stall_q + 1'b1;
          if (stall_q == StallBits'(TIMEOUT_CYCLES - 1)) begin
            state_d = StFault;
          end
        end
`endif
      end
      StApply: begin
        if (apply_hs) begin
          if (last_gate) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + 1'b1;
            state_d = StClear;
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      index_q  <= '0;
      credit_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef GATE_TIMEOUT_EN
      stall_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      index_q  <= index_d;
      credit_q <= credit_d;
      done_q   <= done_d;
`ifdef GATE_TIMEOUT_EN
      stall_q  <= stall_d;
`endif
    end
  end

  // Outputs are forced low while reset is asserted; the decoder is held in reset alongside.
  assign bus.src_ready   = src_ready;
  assign bus.dec_ready   = xfer;
  assign bus.dec_cell    = reset_n ? bus.src_data : '0;
  assign bus.dec_reset   = !reset_n || (state_q == StClear);
  assign bus.apply_valid = reset_n && (state_q == StApply);
  assign bus.gate_index  = reset_n ? index_q : '0;
  assign bus.busy        = reset_n && (state_q inside {StClear, StLoad, StApply});
  assign bus.done        = reset_n && done_q;
`ifdef GATE_TIMEOUT_EN
  assign bus.error       = reset_n && (state_q == StFault);
`else
  assign bus.error       = 1'b0;
`endif

endmodule

// File: tb/tb_gate_stream_scheduler.sv
// Scoreboard bench for gate_stream_scheduler with a behavioural serial decoder,
// a gap-capable source and an apply-side backpressure driver.
module tb_gate_stream_scheduler;
  localparam int unsigned NB = 37;
  localparam int unsigned CB = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gate_stream_if #(.NUMBER_BITS(NB), .COUNT_BITS(CB)) bus ();

  gate_stream_scheduler #(
    .NUMBER_BITS(NB),
    .COUNT_BITS(CB),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    logic signed [NB-1:0] val;
    int                   cyc;
  } cell_t;
  typedef struct {
    int idx;
    int cyc;
  } apply_t;

  cell_t  cell_exp[$];
  apply_t apply_exp[$];
  int     done_exp[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n_dreset = 0;
  int n_xfer = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Behavioural decoder: requests cells one at a time until it holds 8.
  int   dm_cnt = 0;
  logic dm_outst = 1'b0;
  always @(posedge clk) begin
    if (bus.dec_reset) begin
      dm_cnt   <= 0;
      dm_outst <= 1'b0;
    end else if (bus.dec_ready) begin
      dm_cnt   <= dm_cnt + 1;
      dm_outst <= 1'b0;
    end else if (bus.dec_needs_number) begin
      dm_outst <= 1'b1;
    end
  end
  assign bus.dec_needs_number = !bus.dec_reset && !dm_outst && (dm_cnt < 8);
  assign bus.dec_done = (dm_cnt == 8);

  // Source: each queued cell may be preceded by a number of idle cycles.
  logic signed [NB-1:0] src_fifo[$];
  int                   gap_fifo[$];
  initial begin
    logic took;
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    forever begin
      @(negedge clk);
      took = bus.src_valid && bus.src_ready;
      @(posedge clk);
      #2;
      if (took && src_fifo.size() > 0) begin
        void'(src_fifo.pop_front());
        void'(gap_fifo.pop_front());
      end
      if (src_fifo.size() == 0) begin
        bus.src_valid = 1'b0;
      end else if (gap_fifo[0] > 0) begin
        bus.src_valid = 1'b0;
        gap_fifo[0] = gap_fifo[0] - 1;
      end else begin
        bus.src_valid = 1'b1;
        bus.src_data  = src_fifo[0];
      end
    end
  end

  // Apply side: withholds ready for ar_stall cycles of each offer.
  int ar_stall = 0;
  initial begin
    int av_cnt = 0;
    bus.apply_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (bus.apply_valid) begin
        av_cnt++;
        bus.apply_ready = (av_cnt > ar_stall);
      end else begin
        av_cnt = 0;
        bus.apply_ready = (ar_stall == 0);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transfer, offer or done.
  initial begin
    logic ap_wait = 1'b0;
    int   ap_idx = 0;
    cell_t  c;
    apply_t a;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.dec_reset) n_dreset++;
        if (bus.dec_ready) begin
          n_xfer++;
          if (cell_exp.size() == 0) chk("unexpected_cell", 1, 0);
          else begin
            c = cell_exp.pop_front();
            chk("cell_value", bus.dec_cell, c.val);
            chk("cell_cycle", cyc, c.cyc);
          end
        end
        if (ap_wait) begin
          chk("apply_hold_valid", bus.apply_valid, 1);
          chk("apply_hold_index", bus.gate_index, ap_idx);
        end
        if (bus.apply_valid && bus.apply_ready) begin
          if (apply_exp.size() == 0) chk("unexpected_apply", 1, 0);
          else begin
            a = apply_exp.pop_front();
            chk("apply_index", bus.gate_index, a.idx);
            chk("apply_cycle", cyc, a.cyc);
          end
        end
        if (bus.done) begin
          if (done_exp.size() == 0) chk("unexpected_done", 1, 0);
          else chk("done_cycle", cyc, done_exp.pop_front());
        end
        ap_wait = bus.apply_valid && !bus.apply_ready;
        ap_idx  = bus.gate_index;
      end else begin
        ap_wait = 1'b0;
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) tick();
  endtask

  task automatic load_gate(int first, int gap_at, int gap_len);
    for (int k = 1; k <= 8; k++) begin
      src_fifo.push_back(NB'(first + k - 1));
      gap_fifo.push_back((k == gap_at) ? gap_len : 0);
    end
  endtask

  // Cell k of a gate whose CLEAR is in cycle base transfers in base+k, shifted by any gap.
  function automatic int expect_gate(int base, int g, int first, int gap_at, int gap_len);
    cell_t  c;
    apply_t a;
    int     extra;
    extra = (gap_at > 0) ? gap_len : 0;
    for (int k = 1; k <= 8; k++) begin
      c.val = NB'(first + k - 1);
      c.cyc = base + k + ((gap_at > 0 && k >= gap_at) ? gap_len : 0);
      cell_exp.push_back(c);
    end
    a.idx = g;
    a.cyc = base + 10 + extra + ar_stall;
    apply_exp.push_back(a);
    return a.cyc;
  endfunction

  task automatic pulse_start(int count);
    bus.gate_count = CB'(count);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((cell_exp.size() + apply_exp.size() + done_exp.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_pending", cell_exp.size() + apply_exp.size() + done_exp.size(), 0);
    cell_exp.delete();
    apply_exp.delete();
    done_exp.delete();
    tick(2);
    chk("idle_after_run", bus.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int base, a, d0, x0;
    cell_t c;
    bus.start = 1'b0;
    bus.gate_count = '0;

    tick(3);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_apply_valid", bus.apply_valid, 0);
    chk("rst_src_ready", bus.src_ready, 0);
    chk("rst_dec_ready", bus.dec_ready, 0);
    chk("rst_dec_reset", bus.dec_reset, 1);
    chk("rst_gate_index", bus.gate_index, 0);
    chk("rst_error", bus.error, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("idle_dec_reset", bus.dec_reset, 0);
    chk("idle_busy", bus.busy, 0);

    // Single gate, cells 1..8, no stalls.
    ar_stall = 0;
    load_gate(1, 0, 0);
    tick();
    d0 = n_dreset; x0 = n_xfer;
    base = cyc + 1;
    a = expect_gate(base, 0, 1, 0, 0);
    done_exp.push_back(a + 1);
    pulse_start(1);
    drain(100);
    chk("single_dec_reset_cycles", n_dreset - d0, 1);
    chk("single_xfers", n_xfer - x0, 8);

    // Three gates with 5 cycles of apply backpressure each; includes negative cells.
    ar_stall = 5;
    load_gate(16, 0, 0); load_gate(-100, 0, 0); load_gate(1000, 0, 0);
    tick();
    d0 = n_dreset; x0 = n_xfer;
    base = cyc + 1;
    a = expect_gate(base, 0, 16, 0, 0);
    a = expect_gate(a + 1, 1, -100, 0, 0);
    a = expect_gate(a + 1, 2, 1000, 0, 0);
    done_exp.push_back(a + 1);
    pulse_start(3);
    drain(200);
    chk("three_dec_reset_cycles", n_dreset - d0, 3);
    chk("three_xfers", n_xfer - x0, 24);
    ar_stall = 0;
    tick(2);

    // Zero gates: done the cycle after start, decoder never cleared.
    d0 = n_dreset;
    done_exp.push_back(cyc + 1);
    pulse_start(0);
    drain(20);
    chk("zero_dec_reset_cycles", n_dreset - d0, 0);

    // Start pulsed mid-run is ignored.
    load_gate(200, 0, 0);
    tick();
    d0 = n_dreset; x0 = n_xfer;
    base = cyc + 1;
    a = expect_gate(base, 0, 200, 0, 0);
    done_exp.push_back(a + 1);
    pulse_start(1);
    tick(3);
    pulse_start(5);
    drain(100);
    chk("ignored_start_dec_reset", n_dreset - d0, 1);
    chk("ignored_start_xfers", n_xfer - x0, 8);

    // Three-cycle source gap before cell 5.
    load_gate(41, 5, 3);
    tick();
    base = cyc + 1;
    a = expect_gate(base, 0, 41, 5, 3);
    done_exp.push_back(a + 1);
    pulse_start(1);
    drain(100);

    // Reset asserted while cell 5 of gate 1 is on offer.
    load_gate(300, 0, 0); load_gate(400, 0, 0);
    tick();
    base = cyc + 1;
    a = expect_gate(base, 0, 300, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      c.val = NB'(400 + k - 1);
      c.cyc = a + 1 + k;
      cell_exp.push_back(c);
    end
    pulse_start(2);
    wait_cyc(a + 6);
    reset_n = 1'b0;
    src_fifo.delete();
    gap_fifo.delete();
    tick();
    @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_dec_reset", bus.dec_reset, 1);
    chk("midrst_gate_index", bus.gate_index, 0);
    chk("midrst_apply_valid", bus.apply_valid, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick(2);
    chk("midrst_leftover_cells", cell_exp.size(), 0);
    chk("midrst_leftover_apply", apply_exp.size(), 0);
    chk("midrst_no_done", done_exp.size(), 0);
    load_gate(500, 0, 0);
    tick();
    base = cyc + 1;
    a = expect_gate(base, 0, 500, 0, 0);
    done_exp.push_back(a + 1);
    pulse_start(1);
    drain(100);

`ifdef GATE_TIMEOUT_EN
    // Source stops after two cells; 16 stalled cycles raise the sticky error.
    src_fifo.push_back(NB'(700)); gap_fifo.push_back(0);
    src_fifo.push_back(NB'(701)); gap_fifo.push_back(0);
    tick();
    base = cyc + 1;
    c.val = NB'(700); c.cyc = base + 1; cell_exp.push_back(c);
    c.val = NB'(701); c.cyc = base + 2; cell_exp.push_back(c);
    pulse_start(1);
    wait_cyc(base + 18);
    @(negedge clk);
    chk("timeout_not_yet", bus.error, 0);
    @(negedge clk);
    chk("timeout_error", bus.error, 1);
    chk("timeout_src_ready", bus.src_ready, 0);
    chk("timeout_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    pulse_start(1);
    tick(2);
    @(negedge clk);
    chk("timeout_sticky", bus.error, 1);
    chk("timeout_start_ignored", bus.dec_reset, 0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    tick();
    @(negedge clk);
    chk("timeout_cleared", bus.error, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick(2);
    chk("timeout_cells_seen", cell_exp.size(), 0);
    cell_exp.delete();
`else
    chk("error_tied_low", bus.error, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
